// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control unit with memory handshake and fault trap
module multicycle_ctrl #(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Instr,
    input  logic              ALU_zero,
    input  logic              Imem_Ack,
    input  logic              Dmem_Ack,
    output logic              Imem_Req,
    output logic              Dmem_Req,
    output logic              IR_LdEn,
    output logic              PC_sel,
    output logic              PC_LdEn,
    output logic              RF_WrEn,
    output logic              RF_WrData_sel,
    output logic              RF_B_sel,
    output logic              ALU_Bin_sel,
    output logic [FUNC_W-1:0] ALU_func,
    output logic              Mem_WrEn,
    output logic [1:0]        Fault,
    output logic [CNT_W-1:0]  Retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b100000);
    localparam logic [OPC_W-1:0] OP_LI   = OPC_W'(6'b111000);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_B    = OPC_W'(6'b111111);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b001111);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b011111);

    state_t              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;

    logic [OPC_W-1:0]    opcode;
    logic                is_r, is_li, is_addi, is_b, is_beq, is_lw, is_sw, is_legal;
    logic [FUNC_W-1:0]   op_alu_func;
    logic                op_alu_bin;
    logic                timeout_hit;

    logic                imem_req, dmem_req, ir_ld, pc_sel, pc_ld;
    logic                rf_wr, rf_wrdata_sel, rf_b_sel, alu_bin, mem_wr;
    logic [FUNC_W-1:0]   alu_func;

    logic                unused_instr;
    assign unused_instr = ^Instr[31-OPC_W:FUNC_W];

    assign opcode   = Instr[31:32-OPC_W];
    assign is_r     = (opcode == OP_R);
    assign is_li    = (opcode == OP_LI);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_b     = (opcode == OP_B);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_legal = is_r | is_li | is_addi | is_b | is_beq | is_lw | is_sw;

    // ALU setup shared by EXEC and the states that must hold it stable
    always_comb begin
        op_alu_func = '0;
        op_alu_bin  = 1'b0;
        if (is_r) begin
            op_alu_func = Instr[FUNC_W-1:0];
        end else if (is_addi || is_li || is_lw || is_sw) begin
            op_alu_bin  = 1'b1;
        end else if (is_beq) begin
            op_alu_func = FUNC_W'(1);
        end
    end

    // The Ack is checked before the timeout, so an Ack on the last allowed cycle wins
    assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_W'(TO_LAST));

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        wait_d        = '0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_ld         = 1'b0;
        pc_sel        = 1'b0;
        pc_ld         = 1'b0;
        rf_wr         = 1'b0;
        rf_wrdata_sel = 1'b0;
        rf_b_sel      = 1'b0;
        alu_bin       = 1'b0;
        alu_func      = '0;
        mem_wr        = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (Imem_Ack) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    fault_d = 2'b10;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                rf_b_sel = is_beq | is_sw;
                if (!is_legal) begin
                    fault_d = 2'b01;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_b_sel = is_beq | is_sw;
                alu_func = op_alu_func;
                alu_bin  = op_alu_bin;
                if (is_beq) begin
                    pc_sel  = ALU_zero;
                    pc_ld   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_b) begin
                    pc_sel  = 1'b1;
                    pc_ld   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mem_wr   = is_sw;
                rf_b_sel = is_sw;
                alu_func = op_alu_func;
                alu_bin  = op_alu_bin;
                if (Dmem_Ack) begin
                    if (is_sw) begin
                        pc_ld   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    fault_d = 2'b11;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                rf_wr         = 1'b1;
                pc_ld         = 1'b1;
                rf_wrdata_sel = is_lw;
                if (!is_lw) begin
                    alu_func = op_alu_func;
                    alu_bin  = op_alu_bin;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_FETCH;
            fault_q   <= 2'b00;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            if (pc_ld) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Every output is held low for the whole of any cycle in which reset is asserted
    assign Imem_Req      = Reset & imem_req;
    assign Dmem_Req      = Reset & dmem_req;
    assign IR_LdEn       = Reset & ir_ld;
    assign PC_sel        = Reset & pc_sel;
    assign PC_LdEn       = Reset & pc_ld;
    assign RF_WrEn       = Reset & rf_wr;
    assign RF_WrData_sel = Reset & rf_wrdata_sel;
    assign RF_B_sel      = Reset & rf_b_sel;
    assign ALU_Bin_sel   = Reset & alu_bin;
    assign ALU_func      = Reset ? alu_func : '0;
    assign Mem_WrEn      = Reset & mem_wr;
    assign Fault         = Reset ? fault_q : 2'b00;
    assign Retired       = Reset ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, ALU_zero, Imem_Ack, Dmem_Ack;
    logic [31:0] Instr;
    logic        Imem_Req, Dmem_Req, IR_LdEn, PC_sel, PC_LdEn, RF_WrEn;
    logic        RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Mem_WrEn;
    logic [3:0]  ALU_func;
    logic [1:0]  Fault;
    logic [31:0] Retired;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] I_RADD = 32'h8000_0000;
    localparam logic [31:0] I_R6   = 32'h8000_0006;
    localparam logic [31:0] I_LW   = 32'h3C00_0000;
    localparam logic [31:0] I_SW   = 32'h7C00_0000;
    localparam logic [31:0] I_BEQ  = 32'h0000_0000;
    localparam logic [31:0] I_B    = 32'hFC00_0000;
    localparam logic [31:0] I_ADDI = 32'hC000_0000;
    localparam logic [31:0] I_ILL  = 32'h5400_0000;

    // {Imem_Req,IR_LdEn, Dmem_Req,Mem_WrEn, PC_LdEn,PC_sel, RF_WrEn,RF_WrData_sel, RF_B_sel,ALU_Bin_sel}
    logic [9:0] ctl;
    assign ctl = {Imem_Req, IR_LdEn, Dmem_Req, Mem_WrEn, PC_LdEn, PC_sel,
                  RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel};

    always #5 Clk = ~Clk;

    multicycle_ctrl #(.OPC_W(6), .FUNC_W(4), .CNT_W(32), .TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
        .Imem_Ack(Imem_Ack), .Dmem_Ack(Dmem_Ack), .Imem_Req(Imem_Req),
        .Dmem_Req(Dmem_Req), .IR_LdEn(IR_LdEn), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn),
        .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
        .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Mem_WrEn(Mem_WrEn),
        .Fault(Fault), .Retired(Retired)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Instr = I_RADD; Imem_Ack = 1'b1; Dmem_Ack = 1'b1; ALU_zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (ctl !== 10'b0 || ALU_func !== 4'h0) begin miscompares++; $display("FAIL reset_ctl: got %b/%h want 0/0", ctl, ALU_func); end
            vectors++;
            if (Fault !== 2'b00 || Retired !== 32'd0) begin miscompares++; $display("FAIL reset_regs: got fault %b ret %0d want 00/0", Fault, Retired); end
        end
        Reset = 1'b1; Dmem_Ack = 1'b0;
    endtask

    task automatic test_r_add();
        Instr = I_RADD; Imem_Ack = 1'b1; #1;
        vectors++;
        if (ctl !== 10'b11_00_00_00_00) begin miscompares++; $display("FAIL radd_fetch: got %b want %b", ctl, 10'b11_00_00_00_00); end
        step(); Imem_Ack = 1'b0; #1;
        vectors++;
        if (ctl !== 10'b00_00_00_00_00) begin miscompares++; $display("FAIL radd_decode: got %b want %b", ctl, 10'b0); end
        step(); step();
        vectors++;
        if (ctl !== 10'b00_00_10_10_00 || ALU_func !== 4'h0) begin miscompares++; $display("FAIL radd_wb: got %b/%h want %b/0", ctl, ALU_func, 10'b00_00_10_10_00); end
        step();
        vectors++;
        if (Retired !== 32'd1) begin miscompares++; $display("FAIL radd_retired: got %0d want 1", Retired); end
    endtask

    task automatic test_lw_wait();
        Instr = I_LW; Imem_Ack = 1'b1; #1;
        step(); Imem_Ack = 1'b0;
        step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_00_00_01 || ALU_func !== 4'h0) begin miscompares++; $display("FAIL lw_exec: got %b/%h want %b/0", ctl, ALU_func, 10'b00_00_00_00_01); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) Dmem_Ack = 1'b1;
            #1;
            vectors++;
            if (ctl !== 10'b00_10_00_00_01) begin miscompares++; $display("FAIL lw_mem%0d: got %b want %b", k, ctl, 10'b00_10_00_00_01); end
        end
        step(); Dmem_Ack = 1'b0; #1;
        vectors++;
        if (ctl !== 10'b00_00_10_11_00) begin miscompares++; $display("FAIL lw_wb: got %b want %b", ctl, 10'b00_00_10_11_00); end
        step();
        vectors++;
        if (Retired !== 32'd2 || Imem_Req !== 1'b1) begin miscompares++; $display("FAIL lw_done: got ret %0d req %b want 2/1", Retired, Imem_Req); end
    endtask

    task automatic test_beq();
        Instr = I_BEQ; Imem_Ack = 1'b1; ALU_zero = 1'b1; #1;
        step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_00_00_10) begin miscompares++; $display("FAIL beq_decode: got %b want %b", ctl, 10'b00_00_00_00_10); end
        step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_11_00_10 || ALU_func !== 4'h1) begin miscompares++; $display("FAIL beq_taken: got %b/%h want %b/1", ctl, ALU_func, 10'b00_00_11_00_10); end
        step(); ALU_zero = 1'b0;
        step(); step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_10_00_10 || ALU_func !== 4'h1) begin miscompares++; $display("FAIL beq_not_taken: got %b/%h want %b/1", ctl, ALU_func, 10'b00_00_10_00_10); end
        step(); Imem_Ack = 1'b0; #1;
        vectors++;
        if (Retired !== 32'd4) begin miscompares++; $display("FAIL beq_retired: got %0d want 4", Retired); end
    endtask

    task automatic test_sw();
        Instr = I_SW; Imem_Ack = 1'b1; #1;
        step(); Imem_Ack = 1'b0;
        step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_00_00_11) begin miscompares++; $display("FAIL sw_exec: got %b want %b", ctl, 10'b00_00_00_00_11); end
        step(); Dmem_Ack = 1'b1; #1;
        vectors++;
        if (ctl !== 10'b00_11_10_00_11) begin miscompares++; $display("FAIL sw_mem_ack: got %b want %b", ctl, 10'b00_11_10_00_11); end
        step(); Dmem_Ack = 1'b0; #1;
        vectors++;
        if (Retired !== 32'd5) begin miscompares++; $display("FAIL sw_retired: got %0d want 5", Retired); end
    endtask

    task automatic test_back_to_back();
        Instr = I_B; Imem_Ack = 1'b1; #1;
        step(); step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_11_00_00) begin miscompares++; $display("FAIL b_exec: got %b want %b", ctl, 10'b00_00_11_00_00); end
        step(); Instr = I_ADDI; #1;
        step(); step(); step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_10_10_01 || ALU_func !== 4'h0) begin miscompares++; $display("FAIL addi_wb: got %b/%h want %b/0", ctl, ALU_func, 10'b00_00_10_10_01); end
        step(); Instr = I_R6; #1;
        step(); step(); #1;
        vectors++;
        if (ALU_func !== 4'h6 || ctl !== 10'b0) begin miscompares++; $display("FAIL r6_exec: got %b/%h want 0/6", ctl, ALU_func); end
        step(); #1;
        vectors++;
        if (ALU_func !== 4'h6 || ctl !== 10'b00_00_10_10_00) begin miscompares++; $display("FAIL r6_wb: got %b/%h want %b/6", ctl, ALU_func, 10'b00_00_10_10_00); end
        step(); Imem_Ack = 1'b0; #1;
        vectors++;
        if (Retired !== 32'd8) begin miscompares++; $display("FAIL b2b_retired: got %0d want 8", Retired); end
    endtask

    task automatic test_illegal();
        Instr = I_ILL; Imem_Ack = 1'b1; #1;
        step(); #1;
        vectors++;
        if (Fault !== 2'b00) begin miscompares++; $display("FAIL ill_decode_fault: got %b want 00", Fault); end
        for (int k = 0; k < 4; k++) begin
            step(); Imem_Ack = k[0]; Dmem_Ack = ~k[0]; #1;
            vectors++;
            if (ctl !== 10'b0 || Fault !== 2'b01 || Retired !== 32'd8) begin miscompares++; $display("FAIL ill_trap%0d: got %b fault %b ret %0d want 0/01/8", k, ctl, Fault, Retired); end
        end
        Reset = 1'b0; Dmem_Ack = 1'b0; Imem_Ack = 1'b0;
        step();
        vectors++;
        if (Fault !== 2'b00) begin miscompares++; $display("FAIL ill_clear: got %b want 00", Fault); end
        Reset = 1'b1;
    endtask

    task automatic test_timeout();
        Instr = I_RADD; Imem_Ack = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            vectors++;
            if (Imem_Req !== 1'b1 || Fault !== 2'b00) begin miscompares++; $display("FAIL to_wait%0d: got req %b fault %b want 1/00", k, Imem_Req, Fault); end
            if (k < 16) step();
        end
        step();
        vectors++;
        if (Fault !== 2'b10 || ctl !== 10'b0) begin miscompares++; $display("FAIL to_trap: got fault %b ctl %b want 10/0", Fault, ctl); end
        Reset = 1'b0; step(); Reset = 1'b1;
        for (int k = 1; k < 16; k++) step();
        Imem_Ack = 1'b1; #1;
        vectors++;
        if (IR_LdEn !== 1'b1) begin miscompares++; $display("FAIL to_late_ack: got %b want 1", IR_LdEn); end
        step(); Imem_Ack = 1'b0; #1;
        vectors++;
        if (Fault !== 2'b00) begin miscompares++; $display("FAIL to_no_fault: got %b want 00", Fault); end
        step(); step(); #1;
        vectors++;
        if (ctl !== 10'b00_00_10_10_00) begin miscompares++; $display("FAIL to_wb: got %b want %b", ctl, 10'b00_00_10_10_00); end
        step();
        vectors++;
        if (Retired !== 32'd1) begin miscompares++; $display("FAIL to_retired: got %0d want 1", Retired); end
    endtask

    task automatic test_reset_in_mem();
        Instr = I_SW; Imem_Ack = 1'b1; #1;
        step(); Imem_Ack = 1'b0;
        step(); step(); #1;
        vectors++;
        if (ctl !== 10'b00_11_00_00_11) begin miscompares++; $display("FAIL rim_mem: got %b want %b", ctl, 10'b00_11_00_00_11); end
        Reset = 1'b0; #1;
        vectors++;
        if (ctl !== 10'b0) begin miscompares++; $display("FAIL rim_forced: got %b want 0", ctl); end
        step(); Reset = 1'b1; #1;
        vectors++;
        if (ctl !== 10'b10_00_00_00_00 || Retired !== 32'd0 || Fault !== 2'b00) begin miscompares++; $display("FAIL rim_after: got %b ret %0d fault %b want %b/0/00", ctl, Retired, Fault, 10'b10_00_00_00_00); end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_lw_wait();
        test_beq();
        test_sw();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_in_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name:
multicycle_ctrl

Overview:
- Parametrised multicycle control unit, successor to the single-cycle control block.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using the existing IF/DEC/ALU/MEM stage signals.
- Adds a request/acknowledge handshake to instruction and data memory with variable latency, plus a timeout.
- Adds a retired-instruction counter and a sticky fault trap.

Parameters:
- OPC_W, 6: opcode width, taken from Instr[31:32-OPC_W].
- FUNC_W, 4: ALU_func width; R-type func is Instr[FUNC_W-1:0].
- CNT_W, 32: width of the Retired counter.
- TIMEOUT, 16: maximum cycles waiting for an Ack before trapping; 0 disables the timeout.

Ports:
- Clk, in, 1: clock, rising edge.
- Reset, in, 1: synchronous, active-low reset.
- Instr, in, 32: instruction register output.
- ALU_zero, in, 1: ALU result equals zero.
- Imem_Ack, in, 1: instruction memory data valid.
- Dmem_Ack, in, 1: data memory access complete.
- Imem_Req, out, 1: instruction fetch request.
- Dmem_Req, out, 1: data memory request.
- IR_LdEn, out, 1: load the instruction register.
- PC_sel, out, 1: 0 selects PC+4; 1 selects PC+4+Immed.
- PC_LdEn, out, 1: update the PC; marks the end of an instruction.
- RF_WrEn, out, 1: register file write enable.
- RF_WrData_sel, out, 1: 0 selects ALU_out; 1 selects MEM_out.
- RF_B_sel, out, 1: 1 for sw and beq (second read port uses the rd field).
- ALU_Bin_sel, out, 1: 0 selects RF_B; 1 selects Immed.
- ALU_func, out, FUNC_W: ALU operation.
- Mem_WrEn, out, 1: data memory write enable.
- Fault, out, 2: 00 none, 01 illegal opcode, 10 Imem timeout, 11 Dmem timeout.
- Retired, out, CNT_W: count of completed instructions.

Behaviour:
- Reset:
  - While Reset=0 at a Clk edge: state=FETCH, Retired=0, Fault=00, wait counter=0.
  - Outputs are forced to 0 during any cycle with Reset=0, including reset asserted mid-instruction. The in-flight instruction is abandoned and not counted.
- Output timing: all outputs are combinational decodes of the registered state and Instr. Fault and Retired are registered.
- Opcodes: R=100000, li=111000, addi=110000, b=111111, beq=000000, lw=001111, sw=011111. Any other opcode is illegal.
- FETCH:
  - Imem_Req=1.
  - On Imem_Ack=1: IR_LdEn=1 in the same cycle, next state DECODE.
- DECODE:
  - One cycle. RF_B_sel is driven per opcode.
  - Illegal opcode: Fault<=01, next state TRAP.
  - Otherwise next state EXEC.
- EXEC, ALU_func by opcode:
  - R: Instr[FUNC_W-1:0].
  - addi, li, lw, sw: 0000 (add), ALU_Bin_sel=1.
  - beq: 0001 (sub), ALU_Bin_sel=0.
- EXEC, next state by opcode:
  - beq: PC_sel=ALU_zero, PC_LdEn=1, next state FETCH.
  - b: PC_sel=1, PC_LdEn=1, next state FETCH.
  - R, addi, li: next state WB.
  - lw, sw: next state MEM.
- MEM:
  - Dmem_Req=1 and ALU_func/ALU_Bin_sel are held. Mem_WrEn=1 for sw, held with Dmem_Req.
  - On Dmem_Ack: sw asserts PC_LdEn=1 (PC_sel=0) and goes to FETCH; lw goes to WB.
- WB:
  - RF_WrEn=1 and PC_LdEn=1 (PC_sel=0), next state FETCH.
  - RF_WrData_sel=1 for lw, else 0. ALU controls are held for R/addi/li.
- Retired: increments by 1 on every cycle with PC_LdEn=1. Wraps modulo 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle without Ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without Ack: Fault<=10 (FETCH) or 11 (MEM), next state TRAP.
  - An Ack arriving in the same cycle the counter reaches TIMEOUT wins; no fault is raised.
- TRAP: all control outputs are 0 and Fault is held until Reset=0. Retired is frozen.
- Ack outside its wait state (Imem_Ack outside FETCH, Dmem_Ack outside MEM): ignored.
- Latency with zero-wait memories (Ack in the first request cycle):
  - b, beq: 3 cycles.
  - R, addi, li, sw: 4 cycles.
  - lw: 5 cycles.

Test Plan:
- Reset low for 2 cycles, then high; Imem_Ack=1 and Instr=R add (func 0000) -> FETCH, DECODE, EXEC, WB. RF_WrEn=1 and PC_LdEn=1 in cycle 4; Retired=1.
- lw with Dmem_Ack delayed 3 cycles -> Dmem_Req high for 4 cycles, Mem_WrEn=0. WB asserts RF_WrEn=1 with RF_WrData_sel=1. Total 8 cycles.
- beq with ALU_zero=1, then beq with ALU_zero=0 -> PC_sel=1 then 0, PC_LdEn=1 in EXEC of each, no RF_WrEn. Retired advances by 2.
- Opcode 010101 -> TRAP after DECODE, Fault=01, outputs 0. Imem_Ack pulses ignored; Reset low clears Fault to 00.
- TIMEOUT=16 with Imem_Ack held 0 -> Fault=10 after 16 FETCH cycles. Rerun with Imem_Ack at cycle 16 -> no fault, normal decode.
- Reset asserted in MEM of sw with Dmem_Req=1 -> next cycle FETCH, Dmem_Req=0, Mem_WrEn=0, Retired=0.
